umi_regfile_ep: RTL and testbench
=================================

Name: umi_regfile_ep

Overview:
- Single-clock UMI device endpoint holding a small bank of DW-bit registers.
- Consumes the request stream at the output of umi_fifo_flex, at ODW width.
- Returns read and write responses on a UMI response port that feeds the response-side umi_fifo_flex.
- Acts as a lightweight, synthesizable replacement for umi_mem_agent for control/status space.

Parameters:
- DW, 32, data width; power of 2, 8..256
- AW, 64, address width
- CW, 32, command width
- NREG, 16, number of DW-bit registers; power of 2, ≥2
- BASE, 0, register bank base address (AW bits, aligned to NREG*DW/8)

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous active-low reset
- udev_req_valid  in  1  request valid
- udev_req_cmd  in  CW  request command
- udev_req_dstaddr  in  AW  register byte address
- udev_req_srcaddr  in  AW  requester address, returned as response dstaddr
- udev_req_data  in  DW  write data
- udev_req_ready  out  1  request accepted
- udev_resp_valid  out  1  response valid
- udev_resp_cmd  out  CW  response command
- udev_resp_dstaddr  out  AW  equals latched req srcaddr
- udev_resp_srcaddr  out  AW  equals latched req dstaddr
- udev_resp_data  out  DW  read data; 0 for write responses
- udev_resp_ready  in  1  response accepted

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (nreset).
- cmd fields:
  - opcode = cmd[4:0]: REQ_READ 5'h01, REQ_WRITE 5'h03, REQ_POSTED 5'h05, RESP_READ 5'h02, RESP_WRITE 5'h04.
  - size = cmd[7:5]; len = cmd[15:8]; err = cmd[26:25].
  - All other bits are copied unchanged from request to response.
- Reset, applied at the clk edge with nreset=0:
  - state IDLE, udev_resp_valid=0, udev_req_ready=0.
  - resp cmd/addr/data regs = 0; all registers = 0.
- FSM:
  - IDLE: udev_req_ready=1. A handshake (valid&ready) latches the request and performs the access in that cycle.
    - Write or posted write: registers update at the same clk edge.
    - Read: data is registered.
    - Next state RESP, except posted writes, which stay in IDLE (back-to-back posted writes at 1/cycle).
  - RESP: udev_req_ready=0 and udev_resp_valid=1. Response outputs are stable until udev_resp_ready=1, then go to IDLE.
  - Minimum request-to-response latency: 1 cycle. Throughput for non-posted requests: 1 per 2 cycles.
- Register index = (dstaddr - BASE) >> log2(DW/8), modulo NREG.
- Byte lanes:
  - Bytes per access = 2^size, with size ≤ log2(DW/8).
  - Lane offset = dstaddr[log2(DW/8)-1:0], aligned down to 2^size.
  - Writes update only the enabled bytes. Reads return the full word.
- Illegal requests: len≠0, size>log2(DW/8), or unknown opcode.
  - No register update.
  - Response opcode is RESP_WRITE for write/unknown opcodes, RESP_READ for read; err=2'b11 (DEVERR); data=0.
  - Illegal posted writes are dropped silently.
- Response cmd:
  - opcode = RESP_READ for reads, RESP_WRITE for writes.
  - err = 2'b00 unless an error applies.
  - Other bits copied unchanged from the request.
- Simultaneous events:
  - No new request is accepted while in RESP.
  - resp_ready with resp_valid=0 is ignored.
- nreset=0 mid-transaction: a pending response is discarded, all registers clear, and udev_resp_valid drops at that edge.

Optional Feature:
- Macro: UMI_REGFILE_EP_RANGECHK_EN.
- Defined: a dstaddr outside [BASE, BASE+NREG*DW/8) is illegal (DEVERR, no write).
- Undefined: addresses alias modulo NREG and no range error is reported.

Decomposition:
- umi_regfile_ep_pkg:
  - opcode localparams REQ_READ, REQ_WRITE, REQ_POSTED, RESP_READ, RESP_WRITE
  - ERR_OK, ERR_DEV
  - FSM state enum {IDLE, RESP}
  - function decoding size/offset into a byte-enable mask
- One sub-module, umi_regfile_ep_bank: register array with byte-enable write port and combinational read port. The FSM and response path stay in the top level.

Test Plan:
- Write then read: REQ_WRITE at dstaddr BASE+0x8, size=2, data 0xDEADBEEF, then REQ_READ at the same address.
  - First response: RESP_WRITE, err=0, resp_dstaddr = req srcaddr.
  - Second response: RESP_READ, data 0xDEADBEEF.
- Byte write: reg2=0x11223344, then size=0 write of 0xAA at BASE+0x9.
  - A read of reg2 returns 0x1122AA44.
- Backpressure: hold udev_resp_ready=0 for 5 cycles after a read.
  - resp_valid stays 1 with data/cmd stable; req_ready stays 0; exactly one response after ready rises.
- Posted writes: 4 back-to-back REQ_POSTED.
  - Accepted in 4 consecutive cycles; no responses; all 4 registers updated.
- Illegal request: len=1 write of 0x55 to reg0.
  - Response RESP_WRITE with err=2'b11; reg0 unchanged.
  - With the macro defined, a read at BASE+NREG*4 also returns err=2'b11.
- Reset in RESP: assert nreset=0 while resp_valid=1.
  - Next edge: resp_valid=0; a read of reg0 returns 0.

Source files
------------

// File: rtl/umi_regfile_ep_pkg.sv
// umi_regfile_ep_pkg
//   Shared definitions for the UMI register-file endpoint:
//   - UMI opcodes for the request and response directions
//   - response error codes
//   - endpoint FSM state type
//   - byte_mask(): turns a UMI size/lane offset into a byte-enable mask
package umi_regfile_ep_pkg;

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] REQ_POSTED = 5'h05;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DEV = 2'b11;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    // 2^size enabled bytes starting at the lane offset, aligned down to 2^size.
    // Sized for the widest supported word (32 bytes); callers truncate.
    function automatic logic [31:0] byte_mask(input logic [2:0] size,
                                              input logic [4:0] offset);
        logic [63:0] ones;
        logic [4:0]  align;
        logic [63:0] m;
        ones  = (64'd1 << (8'd1 << size)) - 64'd1;
        align = offset & ~((5'd1 << size) - 5'd1);
        m     = ones << align;
        return m[31:0];
    endfunction

endpackage

// File: rtl/umi_regfile_ep_bank.sv
// umi_regfile_ep_bank
//   NREG x DW register array, cleared by synchronous active-low reset.
//   Ports:
//     clk, nreset       clock, synchronous active-low reset
//     we, wmask, waddr  write enable, per-byte enables, register index
//     wdata             write data (lane-aligned)
//     raddr, rdata      combinational read port
module umi_regfile_ep_bank #(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int IW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            we,
    input  logic [DW/8-1:0] wmask,
    input  logic [IW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [IW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int unsigned i = 0; i < unsigned'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < unsigned'(DW / 8); b++) begin
                if (wmask[b]) begin
                    regs[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = regs[raddr];
    end

endmodule

// File: rtl/umi_regfile_ep.sv
// umi_regfile_ep
//   UMI device endpoint exposing NREG DW-bit control/status registers.
//   Requests are consumed one at a time; reads and writes produce one
//   response, posted writes produce none and can be accepted every cycle.
//   Illegal requests (len!=0, oversized, unknown opcode) get a DEVERR response.
//   Optional: define UMI_REGFILE_EP_RANGECHK_EN to flag addresses outside
//   [BASE, BASE+NREG*DW/8) as DEVERR instead of aliasing modulo NREG.
//   Ports:
//     clk, nreset              clock, synchronous active-low reset
//     udev_req_*               request stream in (valid/ready handshake)
//     udev_resp_*              response stream out (valid/ready handshake)
module umi_regfile_ep
    import umi_regfile_ep_pkg::*;
#(
    parameter int            DW   = 32,
    parameter int            AW   = 64,
    parameter int            CW   = 32,
    parameter int            NREG = 16,
    parameter logic [AW-1:0] BASE = '0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready
);

    localparam int NB  = DW / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = $clog2(NREG);

    state_t        state;
    logic [4:0]    opcode;
    logic [2:0]    size;
    logic [7:0]    len;
    logic          is_read;
    logic          is_write;
    logic          is_posted;
    logic          range_err;
    logic          illegal;
    logic          hs;
    logic          do_write;
    logic [AW-1:0] rel;
    logic [IW-1:0] idx;
    logic [4:0]    offset;
    logic [NB-1:0] wmask;
    logic [DW-1:0] rdata;
    logic [CW-1:0] resp_cmd_nxt;

    always_comb begin
        opcode    = udev_req_cmd[4:0];
        size      = udev_req_cmd[7:5];
        len       = udev_req_cmd[15:8];
        is_read   = (opcode == REQ_READ);
        is_write  = (opcode == REQ_WRITE);
        is_posted = (opcode == REQ_POSTED);
        rel       = udev_req_dstaddr - BASE;
        idx       = IW'(rel >> LSB);
        offset    = 5'(udev_req_dstaddr & AW'(NB - 1));
        wmask     = NB'(byte_mask(size, offset));
`ifdef UMI_REGFILE_EP_RANGECHK_EN
        range_err = (udev_req_dstaddr < BASE) || (rel >= AW'(NREG * NB));
`else
        range_err = 1'b0;
`endif
        illegal   = (len != 8'd0) || (size > 3'(LSB)) ||
                    !(is_read || is_write || is_posted) || range_err;
        // ready is only ever high in IDLE, so no state term is needed here
        hs        = udev_req_valid && udev_req_ready;
        do_write  = hs && (is_write || is_posted) && !illegal;

        resp_cmd_nxt         = udev_req_cmd;
        resp_cmd_nxt[4:0]    = is_read ? RESP_READ : RESP_WRITE;
        resp_cmd_nxt[26:25]  = illegal ? ERR_DEV : ERR_OK;
    end

    umi_regfile_ep_bank #(
        .DW   (DW),
        .NREG (NREG),
        .IW   (IW)
    ) u_bank (
        .clk    (clk),
        .nreset (nreset),
        .we     (do_write),
        .wmask  (wmask),
        .waddr  (idx),
        .wdata  (udev_req_data),
        .raddr  (idx),
        .rdata  (rdata)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state             <= IDLE;
            udev_req_ready    <= 1'b0;
            udev_resp_valid   <= 1'b0;
            udev_resp_cmd     <= '0;
            udev_resp_dstaddr <= '0;
            udev_resp_srcaddr <= '0;
            udev_resp_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    udev_req_ready <= 1'b1;
                    // posted writes (legal or dropped) never leave IDLE
                    if (hs && !is_posted) begin
                        state             <= RESP;
                        udev_req_ready    <= 1'b0;
                        udev_resp_valid   <= 1'b1;
                        udev_resp_cmd     <= resp_cmd_nxt;
                        udev_resp_dstaddr <= udev_req_srcaddr;
                        udev_resp_srcaddr <= udev_req_dstaddr;
                        udev_resp_data    <= (is_read && !illegal) ? rdata : '0;
                    end
                end
                RESP: begin
                    if (udev_resp_ready) begin
                        state           <= IDLE;
                        udev_req_ready  <= 1'b1;
                        udev_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    udev_req_ready  <= 1'b0;
                    udev_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_umi_regfile_ep.sv
module tb_umi_regfile_ep;

    localparam int          DW   = 32;
    localparam int          AW   = 64;
    localparam int          CW   = 32;
    localparam int          NREG = 16;
    localparam logic [63:0] BASE = 64'h4000;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          udev_req_valid = 1'b0;
    logic [CW-1:0] udev_req_cmd = '0;
    logic [AW-1:0] udev_req_dstaddr = '0;
    logic [AW-1:0] udev_req_srcaddr = '0;
    logic [DW-1:0] udev_req_data = '0;
    logic          udev_req_ready;
    logic          udev_resp_valid;
    logic [CW-1:0] udev_resp_cmd;
    logic [AW-1:0] udev_resp_dstaddr;
    logic [AW-1:0] udev_resp_srcaddr;
    logic [DW-1:0] udev_resp_data;
    logic          udev_resp_ready = 1'b0;

    int asserts = 0;
    int fails = 0;

    logic [31:0] mreg [NREG];

    umi_regfile_ep #(
        .DW   (DW),
        .AW   (AW),
        .CW   (CW),
        .NREG (NREG),
        .BASE (BASE)
    ) dut (
        .clk               (clk),
        .nreset            (nreset),
        .udev_req_valid    (udev_req_valid),
        .udev_req_cmd      (udev_req_cmd),
        .udev_req_dstaddr  (udev_req_dstaddr),
        .udev_req_srcaddr  (udev_req_srcaddr),
        .udev_req_data     (udev_req_data),
        .udev_req_ready    (udev_req_ready),
        .udev_resp_valid   (udev_resp_valid),
        .udev_resp_cmd     (udev_resp_cmd),
        .udev_resp_dstaddr (udev_resp_dstaddr),
        .udev_resp_srcaddr (udev_resp_srcaddr),
        .udev_resp_data    (udev_resp_data),
        .udev_resp_ready   (udev_resp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size,
                                           input logic [7:0] len, input logic [31:0] other);
        logic [31:0] c;
        c = other;
        c[4:0] = op;
        c[7:5] = size;
        c[15:8] = len;
        return c;
    endfunction

    // Reference model: applies the request to mreg and predicts the response.
    function automatic void model(input logic [31:0] cmd, input logic [63:0] dst,
                                  input logic [31:0] data, output bit has_resp,
                                  output logic [31:0] ecmd, output logic [31:0] edata);
        int op, size, len, idx, nbytes, off;
        bit rd, wr, po, bad;
        logic [63:0] rel;
        op = int'(cmd[4:0]);
        size = int'(cmd[7:5]);
        len = int'(cmd[15:8]);
        rd = (op == 1);
        wr = (op == 3);
        po = (op == 5);
        bad = (len != 0) || (size > 2) || !(rd || wr || po);
`ifdef UMI_REGFILE_EP_RANGECHK_EN
        if (dst < BASE || dst >= BASE + 64'(NREG * 4)) bad = 1'b1;
`endif
        rel = dst - BASE;
        idx = int'((rel / 4) % NREG);
        if ((wr || po) && !bad) begin
            nbytes = 1 << size;
            off = (int'(dst % 4) / nbytes) * nbytes;
            for (int b = 0; b < nbytes; b++) begin
                mreg[idx][8*(off+b) +: 8] = data[8*(off+b) +: 8];
            end
        end
        has_resp = !po;
        ecmd = cmd;
        ecmd[4:0] = rd ? 5'h02 : 5'h04;
        ecmd[26:25] = bad ? 2'b11 : 2'b00;
        edata = (rd && !bad) ? mreg[idx] : 32'h0;
    endfunction

    task automatic send(input logic [31:0] cmd, input logic [63:0] dst,
                        input logic [63:0] src, input logic [31:0] data);
        bit accepted;
        accepted = 1'b0;
        udev_req_valid = 1'b1;
        udev_req_cmd = cmd;
        udev_req_dstaddr = dst;
        udev_req_srcaddr = src;
        udev_req_data = data;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (udev_req_ready === 1'b1) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        udev_req_valid = 1'b0;
        asserts++;
        if (!accepted) begin
            fails++;
            $display("FAIL accept_timeout: req_ready never seen within 20 cycles (cmd=%h)", cmd);
        end
    endtask

    task automatic get_resp(output logic [31:0] c, output logic [63:0] d,
                            output logic [63:0] s, output logic [31:0] dat);
        bit got;
        got = 1'b0;
        c = '0; d = '0; s = '0; dat = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (udev_resp_valid === 1'b1) begin
                got = 1'b1;
                c = udev_resp_cmd;
                d = udev_resp_dstaddr;
                s = udev_resp_srcaddr;
                dat = udev_resp_data;
                udev_resp_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        udev_resp_ready = 1'b0;
        asserts++;
        if (!got) begin
            fails++;
            $display("FAIL resp_timeout: resp_valid never seen within 20 cycles");
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        udev_req_valid = 1'b0;
        udev_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        asserts++;
        if (udev_resp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_resp_valid: got %b want 0", udev_resp_valid);
        end
        asserts++;
        if (udev_req_ready !== 1'b0) begin
            fails++; $display("FAIL reset_req_ready: got %b want 0", udev_req_ready);
        end
        asserts++;
        if (udev_resp_cmd !== 32'h0 || udev_resp_data !== 32'h0 ||
            udev_resp_dstaddr !== 64'h0 || udev_resp_srcaddr !== 64'h0) begin
            fails++;
            $display("FAIL reset_resp_regs: cmd=%h data=%h dst=%h src=%h want all 0",
                     udev_resp_cmd, udev_resp_data, udev_resp_dstaddr, udev_resp_srcaddr);
        end
        nreset = 1'b1;
        for (int i = 0; i < NREG; i++) mreg[i] = 32'h0;
        @(posedge clk);
        #1;
        asserts++;
        if (udev_req_ready !== 1'b1) begin
            fails++; $display("FAIL idle_req_ready: got %b want 1", udev_req_ready);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] cmd, ec, ed, gc, gd;
        logic [63:0] src, gdst, gsrc;
        bit hr;
        src = {$urandom, $urandom};
        cmd = mk_cmd(5'h03, 3'd2, 8'd0, $urandom);
        model(cmd, BASE + 64'h8, 32'hDEADBEEF, hr, ec, ed);
        send(cmd, BASE + 64'h8, src, 32'hDEADBEEF);
        asserts++;
        if (udev_resp_valid !== 1'b1) begin
            fails++; $display("FAIL wr_latency: resp_valid=%b one cycle after accept, want 1", udev_resp_valid);
        end
        get_resp(gc, gdst, gsrc, gd);
        asserts++;
        if (gc[4:0] !== 5'h04 || gc[26:25] !== 2'b00 || gc !== ec) begin
            fails++; $display("FAIL wr_resp_cmd: got %h want %h", gc, ec);
        end
        asserts++;
        if (gdst !== src || gsrc !== BASE + 64'h8 || gd !== 32'h0) begin
            fails++;
            $display("FAIL wr_resp_fields: dst=%h src=%h data=%h want %h %h 0",
                     gdst, gsrc, gd, src, BASE + 64'h8);
        end
        cmd = mk_cmd(5'h01, 3'd2, 8'd0, $urandom);
        model(cmd, BASE + 64'h8, 32'h0, hr, ec, ed);
        send(cmd, BASE + 64'h8, src, 32'h0);
        get_resp(gc, gdst, gsrc, gd);
        asserts++;
        if (gd !== 32'hDEADBEEF || gd !== ed) begin
            fails++; $display("FAIL rd_data: got %h want DEADBEEF", gd);
        end
        asserts++;
        if (gc[4:0] !== 5'h02 || gc !== ec) begin
            fails++; $display("FAIL rd_resp_cmd: got %h want %h", gc, ec);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] cmd, ec, ed, gc, gd;
        logic [63:0] gdst, gsrc;
        bit hr;
        cmd = mk_cmd(5'h03, 3'd2, 8'd0, 32'h0);
        model(cmd, BASE + 64'h8, 32'h11223344, hr, ec, ed);
        send(cmd, BASE + 64'h8, 64'h1, 32'h11223344);
        get_resp(gc, gdst, gsrc, gd);
        cmd = mk_cmd(5'h03, 3'd0, 8'd0, 32'h0);
        model(cmd, BASE + 64'h9, 32'h0000AA00, hr, ec, ed);
        send(cmd, BASE + 64'h9, 64'h2, 32'h0000AA00);
        get_resp(gc, gdst, gsrc, gd);
        cmd = mk_cmd(5'h01, 3'd2, 8'd0, 32'h0);
        model(cmd, BASE + 64'h8, 32'h0, hr, ec, ed);
        send(cmd, BASE + 64'h8, 64'h3, 32'h0);
        get_resp(gc, gdst, gsrc, gd);
        asserts++;
        if (gd !== 32'h1122AA44 || gd !== ed) begin
            fails++; $display("FAIL byte_write: got %h want 1122AA44", gd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] cmd, ec, ed, gc, gd, c0, d0;
        logic [63:0] gdst, gsrc;
        bit hr, stable;
        cmd = mk_cmd(5'h01, 3'd2, 8'd0, $urandom);
        model(cmd, BASE + 64'h8, 32'h0, hr, ec, ed);
        send(cmd, BASE + 64'h8, 64'h77, 32'h0);
        c0 = udev_resp_cmd;
        d0 = udev_resp_data;
        // a competing posted write is held valid while the response is stalled
        udev_req_valid = 1'b1;
        udev_req_cmd = mk_cmd(5'h05, 3'd2, 8'd0, 32'h0);
        udev_req_dstaddr = BASE + 64'h14;
        udev_req_data = 32'hCAFEF00D;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (udev_resp_valid !== 1'b1 || udev_req_ready !== 1'b0 ||
                udev_resp_cmd !== c0 || udev_resp_data !== d0) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        udev_req_valid = 1'b0;
        asserts++;
        if (!stable) begin
            fails++; $display("FAIL bp_stable: valid=%b ready=%b cmd=%h data=%h want 1 0 %h %h",
                              udev_resp_valid, udev_req_ready, udev_resp_cmd, udev_resp_data, ec, ed);
        end
        get_resp(gc, gdst, gsrc, gd);
        asserts++;
        if (gc !== ec || gd !== ed) begin
            fails++; $display("FAIL bp_resp: cmd=%h data=%h want %h %h", gc, gd, ec, ed);
        end
        asserts++;
        if (udev_resp_valid !== 1'b0) begin
            fails++; $display("FAIL bp_single_resp: resp_valid=%b after handshake, want 0", udev_resp_valid);
        end
        cmd = mk_cmd(5'h01, 3'd2, 8'd0, 32'h0);
        model(cmd, BASE + 64'h14, 32'h0, hr, ec, ed);
        send(cmd, BASE + 64'h14, 64'h78, 32'h0);
        get_resp(gc, gdst, gsrc, gd);
        asserts++;
        if (gd !== ed) begin
            fails++; $display("FAIL bp_no_accept: reg5=%h want %h", gd, ed);
        end
    endtask

    task automatic test_posted();
        logic [31:0] cmd, ec, ed, gc, gd;
        logic [63:0] gdst, gsrc;
        logic [31:0] pdata [4];
        bit hr, all_rdy, no_resp;
        for (int i = 0; i < 10 && udev_req_ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        all_rdy = 1'b1;
        no_resp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pdata[k] = $urandom;
            cmd = mk_cmd(5'h05, 3'd2, 8'd0, $urandom);
            model(cmd, BASE + 64'(32 + 4 * k), pdata[k], hr, ec, ed);
            udev_req_valid = 1'b1;
            udev_req_cmd = cmd;
            udev_req_dstaddr = BASE + 64'(32 + 4 * k);
            udev_req_data = pdata[k];
            if (udev_req_ready !== 1'b1) all_rdy = 1'b0;
            @(posedge clk);
            #1;
            if (udev_resp_valid !== 1'b0) no_resp = 1'b0;
        end
        udev_req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (udev_resp_valid !== 1'b0) no_resp = 1'b0;
        end
        asserts++;
        if (!all_rdy) begin
            fails++; $display("FAIL posted_rate: req_ready dropped during back-to-back posted writes");
        end
        asserts++;
        if (!no_resp) begin
            fails++; $display("FAIL posted_no_resp: resp_valid seen for posted write");
        end
        for (int k = 0; k < 4; k++) begin
            cmd = mk_cmd(5'h01, 3'd2, 8'd0, 32'h0);
            model(cmd, BASE + 64'(32 + 4 * k), 32'h0, hr, ec, ed);
            send(cmd, BASE + 64'(32 + 4 * k), 64'h5, 32'h0);
            get_resp(gc, gdst, gsrc, gd);
            asserts++;
            if (gd !== pdata[k] || gd !== ed) begin
                fails++; $display("FAIL posted_data[%0d]: got %h want %h", k, gd, pdata[k]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] cmd, ec, ed, gc, gd;
        logic [63:0] gdst, gsrc;
        logic [31:0] icmd [5];
        logic [63:0] iaddr [5];
        bit hr;
        cmd = mk_cmd(5'h03, 3'd2, 8'd1, 32'h0);
        model(cmd, BASE, 32'h55, hr, ec, ed);
        send(cmd, BASE, 64'h9, 32'h55);
        get_resp(gc, gdst, gsrc, gd);
        asserts++;
        if (gc[4:0] !== 5'h04 || gc[26:25] !== 2'b11 || gd !== 32'h0) begin
            fails++; $display("FAIL ill_len: cmd=%h data=%h want op 04 err 11 data 0", gc, gd);
        end
        cmd = mk_cmd(5'h01, 3'd2, 8'd0, 32'h0);
        model(cmd, BASE, 32'h0, hr, ec, ed);
        send(cmd, BASE, 64'h9, 32'h0);
        get_resp(gc, gdst, gsrc, gd);
        asserts++;
        if (gd !== ed || gd === 32'h55) begin
            fails++; $display("FAIL ill_no_write: reg0=%h want %h", gd, ed);
        end
        icmd[0] = mk_cmd(5'h01, 3'd3, 8'd0, $urandom);
        iaddr[0] = BASE + 64'h4;
        icmd[1] = mk_cmd(5'h07, 3'd2, 8'd0, $urandom);
        iaddr[1] = BASE + 64'h4;
        icmd[2] = mk_cmd(5'h05, 3'd2, 8'd2, 32'h0);
        iaddr[2] = BASE + 64'h4;
        icmd[3] = mk_cmd(5'h01, 3'd2, 8'd0, $urandom);
        iaddr[3] = BASE + 64'(NREG * 4);
        icmd[4] = mk_cmd(5'h01, 3'd2, 8'd0, $urandom);
        iaddr[4] = BASE + 64'h4;
        for (int k = 0; k < 5; k++) begin
            model(icmd[k], iaddr[k], 32'hFFFFFFFF, hr, ec, ed);
            send(icmd[k], iaddr[k], 64'(k), 32'hFFFFFFFF);
            if (hr) begin
                get_resp(gc, gdst, gsrc, gd);
                asserts++;
                if (gc !== ec || gd !== ed) begin
                    fails++; $display("FAIL ill_case[%0d]: cmd=%h data=%h want %h %h", k, gc, gd, ec, ed);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] cmd, ec, ed, gc, gd, data, other;
        logic [63:0] dst, src, gdst, gsrc;
        logic [4:0] op;
        logic [2:0] size;
        logic [7:0] len;
        bit hr;
        int r;
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) op = 5'h01;
            else if (r < 7) op = 5'h03;
            else if (r < 9) op = 5'h05;
            else begin
                op = 5'($urandom_range(0, 31));
                if (op == 5'h01 || op == 5'h03 || op == 5'h05) op = 5'h1F;
            end
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            len = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            other = $urandom;
            cmd = mk_cmd(op, size, len, other);
            dst = BASE + 64'($urandom_range(0, 127));
            src = {$urandom, $urandom};
            data = $urandom;
            model(cmd, dst, data, hr, ec, ed);
            send(cmd, dst, src, data);
            if (hr) begin
                get_resp(gc, gdst, gsrc, gd);
                asserts++;
                if (gc !== ec || gd !== ed || gdst !== src || gsrc !== dst) begin
                    fails++;
                    $display("FAIL rand[%0d]: cmd=%h data=%h dst=%h src=%h want %h %h %h %h",
                             n, gc, gd, gdst, gsrc, ec, ed, src, dst);
                end
            end else begin
                asserts++;
                if (udev_resp_valid !== 1'b0) begin
                    fails++; $display("FAIL rand_posted[%0d]: resp_valid=%b want 0", n, udev_resp_valid);
                end
            end
        end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] cmd, ec, ed, gc, gd;
        logic [63:0] gdst, gsrc;
        bit hr;
        cmd = mk_cmd(5'h03, 3'd2, 8'd0, 32'h0);
        model(cmd, BASE, 32'h12345678, hr, ec, ed);
        send(cmd, BASE, 64'h1, 32'h12345678);
        get_resp(gc, gdst, gsrc, gd);
        cmd = mk_cmd(5'h01, 3'd2, 8'd0, 32'h0);
        send(cmd, BASE, 64'h2, 32'h0);
        asserts++;
        if (udev_resp_valid !== 1'b1) begin
            fails++; $display("FAIL rst_pending: resp_valid=%b want 1", udev_resp_valid);
        end
        nreset = 1'b0;
        @(posedge clk);
        #1;
        asserts++;
        if (udev_resp_valid !== 1'b0) begin
            fails++; $display("FAIL rst_resp_drop: resp_valid=%b want 0", udev_resp_valid);
        end
        nreset = 1'b1;
        for (int i = 0; i < NREG; i++) mreg[i] = 32'h0;
        model(cmd, BASE, 32'h0, hr, ec, ed);
        send(cmd, BASE, 64'h3, 32'h0);
        get_resp(gc, gdst, gsrc, gd);
        asserts++;
        if (gd !== 32'h0 || gd !== ed) begin
            fails++; $display("FAIL rst_reg_clear: reg0=%h want 0", gd);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_backpressure();
        test_posted();
        test_illegal();
        test_random();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
